fp_mem_wb_stage: RTL and testbench



---
 rtl/fp_mem_wb_stage.sv | 119 +++++++++++
 tb/tb_fp_mem_wb_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mem_wb_stage.sv
// FP MEM/WB stage: FLW/FSW data-memory access over req/ack, then the single FP regfile write port.
// Optional abort of stalled accesses when FP_MEM_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES, 1..255).
module fp_mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result_f_in,
    input  logic [31:0] data_for_writing_to_mem_in,
    input  logic        mem_enable_in,
    input  logic        mem_write_in,
    input  logic        wb_enable_in,
    input  logic [4:0]  rd_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        fp_wb_en,
    output logic [4:0]  fp_wb_rd,
    output logic [31:0] fp_wb_data,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e      state_q;
    logic        wb_flag_q;
    logic [4:0]  rd_q;

`ifdef FP_MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_err    = 1'b0;
`endif

    assign stall_out = (state_q == ACCESS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wb_flag_q    <= 1'b0;
            rd_q         <= 5'd0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            fp_wb_en     <= 1'b0;
            fp_wb_rd     <= 5'd0;
            fp_wb_data   <= 32'd0;
            misalign_err <= 1'b0;
`ifdef FP_MEM_TIMEOUT_EN
            cnt_q        <= 8'd0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            fp_wb_en     <= 1'b0;
            misalign_err <= 1'b0;
`ifdef FP_MEM_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_enable_in) begin
                        if (result_f_in[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end else begin
                            state_q    <= ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write_in;
                            dmem_addr  <= result_f_in;
                            dmem_wdata <= data_for_writing_to_mem_in;
                            rd_q       <= rd_in;
                            // stores never write back, whatever wb_enable says
                            wb_flag_q  <= wb_enable_in & ~mem_write_in;
`ifdef FP_MEM_TIMEOUT_EN
                            cnt_q      <= 8'd0;
`endif
                        end
                    end else if (wb_enable_in) begin
                        fp_wb_en   <= 1'b1;
                        fp_wb_rd   <= rd_in;
                        fp_wb_data <= result_f_in;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state_q  <= IDLE;
                        dmem_req <= 1'b0;
                        if (wb_flag_q) begin
                            fp_wb_en   <= 1'b1;
                            fp_wb_rd   <= rd_q;
                            fp_wb_data <= dmem_rdata;
                        end
`ifdef FP_MEM_TIMEOUT_EN
                    end else if (cnt_q == TO_LAST) begin
                        state_q     <= IDLE;
                        dmem_req    <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mem_wb_stage.sv
// Scoreboarded random bench for fp_mem_wb_stage: a stimulus model pushes expected events,
// a monitor pops them as the DUT shows requests, writebacks and error pulses.
module tb_fp_mem_wb_stage;

    localparam int TO = 4;
    localparam int K_WB = 0, K_MIS = 1, K_MEM = 2, K_TO = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] a;
        logic [31:0] b;
        int          len;
    } ev_t;

    typedef struct {
        int          d;
        logic [31:0] r;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] result_f_in = '0;
    logic [31:0] data_for_writing_to_mem_in = '0;
    logic        mem_enable_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        wb_enable_in = 1'b0;
    logic [4:0]  rd_in = '0;
    logic        stall_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        fp_wb_en;
    logic [4:0]  fp_wb_rd;
    logic [31:0] fp_wb_data;
    logic        misalign_err, timeout_err;

    ev_t  exp_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    fp_mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .result_f_in(result_f_in),
        .data_for_writing_to_mem_in(data_for_writing_to_mem_in),
        .mem_enable_in(mem_enable_in), .mem_write_in(mem_write_in),
        .wb_enable_in(wb_enable_in), .rd_in(rd_in),
        .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .fp_wb_en(fp_wb_en), .fp_wb_rd(fp_wb_rd), .fp_wb_data(fp_wb_data),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_ev(input int kind, output ev_t ev, output bit ok);
        ok = 1'b0;
        ev = '{kind: -1, we: 1'b0, a: '0, b: '0, len: 0};
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, 32'hFFFF_FFFF);
        end else begin
            ev = exp_q.pop_front();
            chk("event_kind", kind, ev.kind);
            ok = (ev.kind == kind);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    initial begin
        ev_t  cur, ev;
        bit   ok, have_cur;
        logic req_prev;
        int   run;
        have_cur = 1'b0;
        req_prev = 1'b0;
        run = 0;
        cur = '{kind: -1, we: 1'b0, a: '0, b: '0, len: 0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("stall_vs_req", stall_out, dmem_req);
                if (dmem_req && !req_prev) begin
                    pop_ev(K_MEM, cur, have_cur);
                    run = 1;
                    if (have_cur) begin
                        chk("req_we", dmem_we, cur.we);
                        chk("req_addr", dmem_addr, cur.a);
                        chk("req_wdata", dmem_wdata, cur.b);
                    end
                end else if (dmem_req && req_prev) begin
                    run++;
                    if (have_cur) begin
                        chk("hold_we", dmem_we, cur.we);
                        chk("hold_addr", dmem_addr, cur.a);
                        chk("hold_wdata", dmem_wdata, cur.b);
                    end
                end else if (!dmem_req && req_prev && have_cur) begin
                    chk("req_cycles", run, cur.len);
                    have_cur = 1'b0;
                end
                req_prev = dmem_req;
                if (fp_wb_en) begin
                    pop_ev(K_WB, ev, ok);
                    if (ok) begin
                        chk("wb_rd", fp_wb_rd, ev.a);
                        chk("wb_data", fp_wb_data, ev.b);
                    end
                end
                if (misalign_err) pop_ev(K_MIS, ev, ok);
                if (timeout_err)  pop_ev(K_TO, ev, ok);
            end
        end
    end

    // Memory responder: serves requests with pre-chosen latency and data, spurious acks when idle
    initial begin
        rsp_t cur;
        bit   busy;
        int   cnt;
        busy = 1'b0;
        cnt = 0;
        cur = '{d: 0, r: '0};
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (mon_en && dmem_req && !busy) begin
                if (rsp_q.size() != 0) cur = rsp_q.pop_front();
                else cur = '{d: 0, r: 32'hDEAD_BEEF};
                cnt = cur.d;
                busy = 1'b1;
            end
            if (busy) begin
                if (cnt == 0) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = cur.r;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (!dmem_req && $urandom_range(0, 3) == 0) begin
                dmem_ack   = 1'b1;
                dmem_rdata = $urandom;
            end
        end
    end

    task automatic idle();
        mem_enable_in = 1'b0;
        mem_write_in  = 1'b0;
        wb_enable_in  = 1'b0;
    endtask

    task automatic wait_capture();
        logic s;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            s = stall_out;
            @(posedge clk);
            n++;
        end while (s && n < 200);
        if (s) chk("capture_timeout", 32'd1, 32'd0);
        #1;
    endtask

    task automatic drive(input logic mem, input logic we, input logic wb, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] wd);
        mem_enable_in = mem;
        mem_write_in  = we;
        wb_enable_in  = wb;
        rd_in         = rd;
        result_f_in   = res;
        data_for_writing_to_mem_in = wd;
    endtask

    // Reference model: expected observable events of one instruction
    task automatic issue(input logic mem, input logic we, input logic wb, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] wd, input int d,
                         input logic [31:0] rdata);
        bit timed_out;
        int len;
        if (!mem) begin
            if (wb) exp_q.push_back('{kind: K_WB, we: 1'b0, a: 32'(rd), b: res, len: 0});
        end else if (res % 4 != 0) begin
            exp_q.push_back('{kind: K_MIS, we: 1'b0, a: '0, b: '0, len: 0});
        end else begin
            timed_out = 1'b0;
            len = d + 1;
`ifdef FP_MEM_TIMEOUT_EN
            if (d + 1 > TO) begin
                timed_out = 1'b1;
                len = TO;
            end
`endif
            exp_q.push_back('{kind: K_MEM, we: we, a: res, b: wd, len: len});
            rsp_q.push_back('{d: d, r: rdata});
            if (timed_out)
                exp_q.push_back('{kind: K_TO, we: 1'b0, a: '0, b: '0, len: 0});
            else if (wb && !we)
                exp_q.push_back('{kind: K_WB, we: 1'b0, a: 32'(rd), b: rdata, len: 0});
        end
        drive(mem, we, wb, rd, res, wd);
        wait_capture();
    endtask

    initial begin
        logic        mem, we, wb;
        logic [4:0]  rd;
        logic [31:0] res, wd, r;
        int          d;

        // Reset dominates a pending memory instruction
        drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0010, 32'h1234_5678);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb_en", fp_wb_en, 0);
        chk("rst_wb_rd", fp_wb_rd, 0);
        chk("rst_wb_data", fp_wb_data, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_stall", stall_out, 0);
        idle();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        issue(1'b0, 1'b0, 1'b1, 5'd5, 32'h4049_0FDB, 32'h0, 0, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0100, 32'h0, 2, 32'h3F80_0000);
        issue(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0200, 32'hC000_0000, 0, 32'h5555_5555);
        issue(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0102, 32'h0, 0, 32'h0);
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 0, 32'h0);
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Reset during an outstanding load; its late ack must be ignored
        exp_q.push_back('{kind: K_MEM, we: 1'b0, a: 32'h300, b: 32'hA5A5_0000, len: 2});
        rsp_q.push_back('{d: 6, r: 32'h0BAD_0BAD});
        drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0300, 32'hA5A5_0000);
        wait_capture();
        idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req", dmem_req, 0);
        chk("midrst_stall", stall_out, 0);
        chk("midrst_wb_en", fp_wb_en, 0);
        repeat (10) @(posedge clk);
        #1;

`ifdef FP_MEM_TIMEOUT_EN
        issue(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0400, 32'h0, 20, 32'h1111_1111);
        idle();
        repeat (25) @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 300; i++) begin
            mem = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            wb  = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            res = $urandom;
            if (mem && $urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            wd  = $urandom;
            d   = $urandom_range(0, 3);
            r   = $urandom;
            issue(mem, we, wb, rd, res, wd, d, r);
        end
        idle();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("events_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
